// File: rtl/spi_frame_ctrl_pkg.sv
// spi_frame_ctrl_pkg: shared FSM state encoding and default widths for the SPI frame sequencer
package spi_frame_ctrl_pkg;
  localparam int CHAR_NBITS_DEF = 16;
  localparam int FIFO_AW_DEF = 3;
  localparam int LEN_W_DEF = 16;
  typedef enum logic [2:0] {IDLE, SETUP, LOAD, XFER, GAP, HOLD} state_t;
endpackage

// File: rtl/spi_frame_ctrl_if.sv
// spi_frame_ctrl_if: host-side FIFO/frame controls plus the per-character handshake to the shifter
interface spi_frame_ctrl_if #(parameter int CHAR_NBITS = 16, parameter int LEN_W = 16);
  logic s_enable, s_tx_only, s_tx_wr, s_tx_full, s_rx_rd, s_rx_empty;
  logic s_frame_start, s_busy, s_frame_done, s_rx_ovf, s_ovf_clr;
  logic s_cs_n, s_char_go, s_char_done;
  logic [CHAR_NBITS-1:0] s_tx_wdata, s_rx_rdata, s_wchar, s_rchar;
  logic [LEN_W-1:0] s_frame_len;
  modport master (
    output s_enable, s_tx_only, s_tx_wr, s_tx_wdata, s_rx_rd, s_frame_len, s_frame_start, s_ovf_clr,
           s_char_done, s_rchar,
    input  s_tx_full, s_rx_rdata, s_rx_empty, s_busy, s_frame_done, s_rx_ovf, s_cs_n, s_char_go, s_wchar
  );
  modport slave (
    input  s_enable, s_tx_only, s_tx_wr, s_tx_wdata, s_rx_rd, s_frame_len, s_frame_start, s_ovf_clr,
           s_char_done, s_rchar,
    output s_tx_full, s_rx_rdata, s_rx_empty, s_busy, s_frame_done, s_rx_ovf, s_cs_n, s_char_go, s_wchar
  );
endinterface

// File: rtl/spi_frame_ctrl_fifo.sv
// spi_frame_ctrl_fifo: single-clock first-word-fall-through FIFO with wrap-bit pointers
module spi_frame_ctrl_fifo #(
  parameter int W = 16,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  output logic         full,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         empty
);
  logic [W-1:0] mem [2**AW];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (wr && !full) mem[wp[AW-1:0]] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(wr && !full);
      rp <= rp + (AW+1)'(rd && !empty);
    end
endmodule

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: sequences chip select and one GO/DONE handshake per char, buffering TX and RX words
module spi_frame_ctrl import spi_frame_ctrl_pkg::*; #(
  parameter int CHAR_NBITS = CHAR_NBITS_DEF,
  parameter int FIFO_AW = FIFO_AW_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD = 2
) (
  input logic s_sysclk,
  input logic s_reset,
  spi_frame_ctrl_if.slave bus
);
  state_t state, state_nx;
  logic [7:0] cnt;
  logic [LEN_W-1:0] rem;
  logic [CHAR_NBITS-1:0] tx_head;
  logic tx_empty, rx_full, pop, push, cnt_end, done_ok;
  assign cnt_end = cnt == 8'(state == SETUP ? CS_SETUP - 1 : CS_HOLD - 1);
  assign pop = state == LOAD && bus.s_enable && !tx_empty;
  assign done_ok = state == XFER && bus.s_enable && bus.s_char_done;
  assign push = done_ok && !bus.s_tx_only;
  spi_frame_ctrl_fifo #(.W(CHAR_NBITS), .AW(FIFO_AW)) u_tx (
    .clk(s_sysclk), .rst(s_reset), .wr(bus.s_tx_wr), .wdata(bus.s_tx_wdata), .full(bus.s_tx_full),
    .rd(pop), .rdata(tx_head), .empty(tx_empty)
  );
  spi_frame_ctrl_fifo #(.W(CHAR_NBITS), .AW(FIFO_AW)) u_rx (
    .clk(s_sysclk), .rst(s_reset), .wr(push), .wdata(bus.s_rchar), .full(rx_full),
    .rd(bus.s_rx_rd), .rdata(bus.s_rx_rdata), .empty(bus.s_rx_empty)
  );
  always_ff @(posedge s_sysclk or posedge s_reset)
    if (s_reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state != IDLE && !bus.s_enable) state_nx = IDLE;
    else
      case (state)
        IDLE:    state_nx = bus.s_frame_start && bus.s_enable && bus.s_frame_len != '0 ? SETUP : IDLE;
        SETUP:   state_nx = cnt_end ? LOAD : SETUP;
        LOAD:    state_nx = tx_empty ? LOAD : XFER;
        XFER:    state_nx = bus.s_char_done ? GAP : XFER;
        GAP:     state_nx = bus.s_char_done ? GAP : rem != '0 ? LOAD : HOLD;
        HOLD:    state_nx = cnt_end ? IDLE : HOLD;
        default: state_nx = IDLE;
      endcase
  end
  always_comb begin
    bus.s_char_go = state == XFER;
    bus.s_cs_n = state == IDLE;
    bus.s_busy = state != IDLE;
  end
  // cnt restarts on every state change, so SETUP and HOLD each count from zero
  always_ff @(posedge s_sysclk or posedge s_reset)
    if (s_reset) begin
      cnt <= '0;
      rem <= '0;
      bus.s_wchar <= '0;
      bus.s_frame_done <= 1'b0;
      bus.s_rx_ovf <= 1'b0;
    end else begin
      cnt <= state_nx != state ? '0 : cnt + 8'd1;
      rem <= state == IDLE && bus.s_frame_start ? bus.s_frame_len : done_ok ? rem - LEN_W'(1) : rem;
      bus.s_wchar <= pop ? tx_head : bus.s_wchar;
      bus.s_frame_done <= (state == HOLD && cnt_end && bus.s_enable) ||
                          (state == IDLE && bus.s_frame_start && bus.s_enable && bus.s_frame_len == '0);
      bus.s_rx_ovf <= (push && rx_full) || (bus.s_rx_ovf && !bus.s_ovf_clr);
    end
endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb_spi_frame_ctrl: directed tests with a loopback char-engine model answering GO after 4 cycles
module tb_spi_frame_ctrl;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  spi_frame_ctrl_if #(.CHAR_NBITS(16), .LEN_W(16)) bus ();
  spi_frame_ctrl #(.CHAR_NBITS(16), .FIFO_AW(3), .LEN_W(16), .CS_SETUP(2), .CS_HOLD(2)) dut (
    .s_sysclk(clk), .s_reset(rst), .bus(bus.slave)
  );
  int nvec = 0, nerr = 0, fd_cnt = 0, go_rises = 0, rcnt = 0;
  logic go_q = 0;
  logic [15:0] sent_q[$];

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      fd_cnt += int'(bus.s_frame_done);
      go_rises += int'(bus.s_char_go && !go_q);
    end
    go_q = bus.s_char_go;
  end

  // char engine model: echoes s_wchar back as s_rchar, holds DONE until GO drops
  initial begin
    bus.s_char_done = 0;
    bus.s_rchar = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        bus.s_char_done = 0;
        rcnt = 0;
      end else if (bus.s_char_done) begin
        if (!bus.s_char_go) bus.s_char_done = 0;
      end else if (bus.s_char_go) begin
        if (rcnt == 3) begin
          bus.s_char_done = 1;
          bus.s_rchar = bus.s_wchar;
          sent_q.push_back(bus.s_wchar);
          rcnt = 0;
        end else rcnt++;
      end else rcnt = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic push(input logic [15:0] d);
    bus.s_tx_wr = 1; bus.s_tx_wdata = d; tick(); bus.s_tx_wr = 0;
  endtask
  task automatic start(input int len);
    bus.s_frame_len = 16'(len); bus.s_frame_start = 1; tick(); bus.s_frame_start = 0;
  endtask
  task automatic rx_pop(); bus.s_rx_rd = 1; tick(); bus.s_rx_rd = 0; endtask
  task automatic wait_frame(output bit ok, output bit cs_bad);
    ok = 0; cs_bad = 0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.s_frame_done) begin ok = 1; break; end
      if (bus.s_cs_n) cs_bad = 1;
      tick();
    end
  endtask
  task automatic wait_go(input logic v, output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (bus.s_char_go === v) begin ok = 1; break; end
      tick();
    end
  endtask
  task automatic wait_sent(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (sent_q.size() >= n) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [6:0] got;
    tick(); tick();
    got = {bus.s_cs_n, bus.s_char_go, bus.s_busy, bus.s_frame_done, bus.s_tx_full, bus.s_rx_empty, bus.s_rx_ovf};
    nvec++; if (got !== 7'b1000010) begin nerr++; $display("FAIL reset_flags got %b want 1000010", got); end
    nvec++; if (bus.s_wchar !== 16'h0) begin nerr++; $display("FAIL reset_wchar got %h want 0000", bus.s_wchar); end
    rst = 0; tick();
  endtask

  task automatic test_basic_frame();
    logic [15:0] exp [3] = '{16'h5A, 16'hA5, 16'h3C};
    int go0, fd0; bit ok, csb;
    foreach (exp[i]) push(exp[i]);
    go0 = go_rises; fd0 = fd_cnt;
    start(3);
    nvec++; if ({bus.s_cs_n, bus.s_busy} !== 2'b01) begin nerr++; $display("FAIL basic_cs_busy got %b want 01", {bus.s_cs_n, bus.s_busy}); end
    tick(); tick();
    nvec++; if (bus.s_char_go !== 1'b0) begin nerr++; $display("FAIL basic_go_early got %b want 0", bus.s_char_go); end
    tick();
    nvec++; if ({bus.s_char_go, bus.s_wchar} !== {1'b1, 16'h5A}) begin nerr++; $display("FAIL basic_first_go got %b/%h want 1/005a", bus.s_char_go, bus.s_wchar); end
    wait_frame(ok, csb);
    nvec++; if (!ok) begin nerr++; $display("FAIL basic_done_timeout got none want frame_done"); end
    nvec++; if (csb) begin nerr++; $display("FAIL basic_cs_low got cs_n high mid-frame want low"); end
    nvec++; if ({bus.s_cs_n, bus.s_busy} !== 2'b10) begin nerr++; $display("FAIL basic_end_cs got %b want 10", {bus.s_cs_n, bus.s_busy}); end
    tick();
    nvec++; if (bus.s_frame_done !== 1'b0) begin nerr++; $display("FAIL basic_done_pulse got %b want 0", bus.s_frame_done); end
    nvec++; if (fd_cnt - fd0 != 1 || go_rises - go0 != 3) begin nerr++; $display("FAIL basic_counts got fd=%0d go=%0d want fd=1 go=3", fd_cnt - fd0, go_rises - go0); end
    foreach (exp[i]) begin
      nvec++; if (bus.s_rx_empty !== 1'b0 || bus.s_rx_rdata !== exp[i]) begin nerr++; $display("FAIL basic_rx%0d got %h want %h", i, bus.s_rx_rdata, exp[i]); end
      rx_pop();
    end
    nvec++; if (bus.s_rx_empty !== 1'b1) begin nerr++; $display("FAIL basic_rx_empty got %b want 1", bus.s_rx_empty); end
  endtask

  task automatic test_stall();
    int go0; bit ok, csb;
    go0 = go_rises;
    start(2);
    repeat (200) tick();
    nvec++; if ({bus.s_char_go, bus.s_cs_n, bus.s_busy} !== 3'b001 || go_rises != go0) begin nerr++; $display("FAIL stall_idle got go/cs/busy=%b rises=%0d want 001 rises=0", {bus.s_char_go, bus.s_cs_n, bus.s_busy}, go_rises - go0); end
    push(16'h11);
    wait_go(1, ok);
    nvec++; if (!ok || bus.s_wchar !== 16'h11) begin nerr++; $display("FAIL stall_first got ok=%0d wchar=%h want 1/0011", ok, bus.s_wchar); end
    repeat (60) tick();
    nvec++; if ({bus.s_char_go, bus.s_cs_n, bus.s_busy} !== 3'b001 || go_rises - go0 != 1) begin nerr++; $display("FAIL stall_second got go/cs/busy=%b rises=%0d want 001 rises=1", {bus.s_char_go, bus.s_cs_n, bus.s_busy}, go_rises - go0); end
    push(16'h22);
    wait_frame(ok, csb);
    nvec++; if (!ok || csb) begin nerr++; $display("FAIL stall_done got ok=%0d cs_bad=%0d want 1/0", ok, csb); end
    nvec++; if (bus.s_rx_rdata !== 16'h11) begin nerr++; $display("FAIL stall_rx0 got %h want 0011", bus.s_rx_rdata); end
    rx_pop();
    nvec++; if (bus.s_rx_rdata !== 16'h22) begin nerr++; $display("FAIL stall_rx1 got %h want 0022", bus.s_rx_rdata); end
    rx_pop();
  endtask

  task automatic test_overflow();
    bit ok, csb;
    for (int i = 0; i < 8; i++) push(16'h100 + 16'(i));
    start(8);
    wait_frame(ok, csb);
    nvec++; if (!ok || bus.s_rx_empty !== 1'b0 || bus.s_rx_ovf !== 1'b0) begin nerr++; $display("FAIL ovf_fill got ok=%0d empty=%b ovf=%b want 1/0/0", ok, bus.s_rx_empty, bus.s_rx_ovf); end
    push(16'hBEEF);
    start(1);
    wait_frame(ok, csb);
    nvec++; if (!ok || bus.s_rx_ovf !== 1'b1) begin nerr++; $display("FAIL ovf_set got ok=%0d ovf=%b want 1/1", ok, bus.s_rx_ovf); end
    for (int i = 0; i < 8; i++) begin
      nvec++; if (bus.s_rx_rdata !== 16'h100 + 16'(i)) begin nerr++; $display("FAIL ovf_rx%0d got %h want %h", i, bus.s_rx_rdata, 16'h100 + 16'(i)); end
      rx_pop();
    end
    nvec++; if (bus.s_rx_empty !== 1'b1 || bus.s_rx_ovf !== 1'b1) begin nerr++; $display("FAIL ovf_sticky got empty=%b ovf=%b want 1/1", bus.s_rx_empty, bus.s_rx_ovf); end
    bus.s_ovf_clr = 1; tick(); bus.s_ovf_clr = 0;
    nvec++; if (bus.s_rx_ovf !== 1'b0) begin nerr++; $display("FAIL ovf_clr got %b want 0", bus.s_rx_ovf); end
  endtask

  task automatic test_abort();
    int fd0, n0; bit ok, ok2, csb;
    for (int i = 0; i < 4; i++) push(16'h41 + 16'(i));
    n0 = sent_q.size(); fd0 = fd_cnt;
    start(4);
    wait_sent(n0 + 1, ok);
    wait_go(0, ok2); ok &= ok2;
    wait_go(1, ok2); ok &= ok2;
    nvec++; if (!ok || bus.s_wchar !== 16'h42) begin nerr++; $display("FAIL abort_second got ok=%0d wchar=%h want 1/0042", ok, bus.s_wchar); end
    bus.s_enable = 0; tick();
    nvec++; if ({bus.s_char_go, bus.s_cs_n, bus.s_busy} !== 3'b010) begin nerr++; $display("FAIL abort_now got go/cs/busy=%b want 010", {bus.s_char_go, bus.s_cs_n, bus.s_busy}); end
    bus.s_enable = 1; repeat (20) tick();
    nvec++; if (fd_cnt != fd0 || bus.s_cs_n !== 1'b1) begin nerr++; $display("FAIL abort_no_done got fd=%0d cs_n=%b want 0/1", fd_cnt - fd0, bus.s_cs_n); end
    nvec++; if (bus.s_rx_rdata !== 16'h41) begin nerr++; $display("FAIL abort_rx got %h want 0041", bus.s_rx_rdata); end
    rx_pop();
    bus.s_tx_only = 1; n0 = sent_q.size();
    start(2);
    wait_frame(ok, csb);
    nvec++; if (!ok || sent_q.size() != n0 + 2) begin nerr++; $display("FAIL abort_rest got ok=%0d sent=%0d want 1/2", ok, sent_q.size() - n0); end
    else begin
      nvec++; if (sent_q[n0] !== 16'h43 || sent_q[n0+1] !== 16'h44) begin nerr++; $display("FAIL abort_left got %h,%h want 0043,0044", sent_q[n0], sent_q[n0+1]); end
    end
    nvec++; if (bus.s_rx_empty !== 1'b1) begin nerr++; $display("FAIL abort_tx_only got empty=%b want 1", bus.s_rx_empty); end
    bus.s_tx_only = 0;
  endtask

  task automatic test_full_len0();
    int n0; bit ok, csb, bad;
    for (int i = 0; i < 8; i++) push(16'h70 + 16'(i));
    nvec++; if (bus.s_tx_full !== 1'b1) begin nerr++; $display("FAIL full_set got %b want 1", bus.s_tx_full); end
    push(16'hFF);
    nvec++; if (bus.s_tx_full !== 1'b1) begin nerr++; $display("FAIL full_9th got %b want 1", bus.s_tx_full); end
    start(0);
    nvec++; if ({bus.s_frame_done, bus.s_cs_n, bus.s_busy} !== 3'b110) begin nerr++; $display("FAIL len0_done got fd/cs/busy=%b want 110", {bus.s_frame_done, bus.s_cs_n, bus.s_busy}); end
    tick();
    nvec++; if ({bus.s_frame_done, bus.s_cs_n} !== 2'b01) begin nerr++; $display("FAIL len0_after got fd/cs=%b want 01", {bus.s_frame_done, bus.s_cs_n}); end
    bus.s_tx_only = 1; n0 = sent_q.size();
    start(8);
    wait_frame(ok, csb);
    bad = !ok || sent_q.size() != n0 + 8;
    if (!bad) for (int i = 0; i < 8; i++) if (sent_q[n0+i] !== 16'h70 + 16'(i)) bad = 1;
    nvec++; if (bad) begin nerr++; $display("FAIL full_drain got ok=%0d sent=%0d want 8 words 0070..0077", ok, sent_q.size() - n0); end
    nvec++; if (bus.s_tx_full !== 1'b0) begin nerr++; $display("FAIL full_clear got %b want 0", bus.s_tx_full); end
    start(1);
    repeat (50) tick();
    nvec++; if ({bus.s_char_go, bus.s_busy} !== 2'b01 || sent_q.size() != n0 + 8) begin nerr++; $display("FAIL full_9th_dropped got go/busy=%b sent=%0d want 01/8", {bus.s_char_go, bus.s_busy}, sent_q.size() - n0); end
    bus.s_enable = 0; tick(); bus.s_enable = 1; bus.s_tx_only = 0; tick();
  endtask

  task automatic test_reset_mid();
    int n0; bit ok, ok2;
    push(16'h98); push(16'h99);
    n0 = sent_q.size();
    start(2);
    wait_sent(n0 + 1, ok);
    wait_go(0, ok2); ok &= ok2;
    wait_go(1, ok2); ok &= ok2;
    nvec++; if (!ok || bus.s_rx_empty !== 1'b0) begin nerr++; $display("FAIL rstmid_pre got ok=%0d empty=%b want 1/0", ok, bus.s_rx_empty); end
    #2 rst = 1;
    #1;
    nvec++; if ({bus.s_char_go, bus.s_cs_n, bus.s_busy, bus.s_rx_empty} !== 4'b0101) begin nerr++; $display("FAIL rstmid_async got go/cs/busy/empty=%b want 0101", {bus.s_char_go, bus.s_cs_n, bus.s_busy, bus.s_rx_empty}); end
    nvec++; if (bus.s_wchar !== 16'h0) begin nerr++; $display("FAIL rstmid_wchar got %h want 0000", bus.s_wchar); end
    tick(); rst = 0; tick();
  endtask

  initial begin
    bus.s_enable = 1; bus.s_tx_only = 0; bus.s_tx_wr = 0; bus.s_tx_wdata = '0; bus.s_rx_rd = 0;
    bus.s_frame_len = '0; bus.s_frame_start = 0; bus.s_ovf_clr = 0;
    test_reset();
    test_basic_frame();
    test_stall();
    test_overflow();
    test_abort();
    test_full_len0();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
